mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing a single `memory2c` instance between the core's instruction-fetch port and its load/store port. It sits between fetch/LSU and the memory, and replaces the dedicated `imem` once data loads/stores are added. The arbiter accepts one request at a time, drives the memory from latched request registers, and returns read data through registered valid pulses. Load/store has priority over fetch, with an optional starvation guard.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive LS grants allowed while IF waits (guard only)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address
- `if_gnt`  out  1  fetch accepted (1-cycle pulse)
- `if_rvalid`  out  1  fetch data valid (1-cycle pulse)
- `if_rdata`  out  DATA_W  fetch data
- `ls_req`  in  1  load/store request, held until `ls_gnt`
- `ls_wr`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDR_W  load/store address
- `ls_wdata`  in  DATA_W  store data
- `ls_gnt`  out  1  load/store accepted (1-cycle pulse)
- `ls_rvalid`  out  1  load data valid / store done (1-cycle pulse)
- `ls_rdata`  out  DATA_W  load data; 0 for stores
- `mem_enable`, `mem_wr`  out  1  to `memory2c` `enable`/`wr`
- `mem_addr`  out  ADDR_W  to `memory2c` `addr`
- `mem_data_in`  out  DATA_W  to `memory2c` `data_in`
- `mem_data_out`  in  DATA_W  from `memory2c` `data_out` (combinational read)
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, SERVE_IF, SERVE_LS, RESP.
- IDLE: requests are sampled only in this state.
  - If any request is pending, select a winner and latch its addr, wdata, wr and port ID.
  - Then go to SERVE_IF or SERVE_LS.
- Arbitration: `ls_req` beats `if_req`, unless the starvation guard forces IF.
- SERVE_x:
  - `mem_enable=1`; `mem_addr`/`mem_data_in` come from the latches.
  - `mem_wr` = latched wr (LS only; always 0 for IF).
  - `x_gnt=1`.
  - For a read, capture `mem_data_out` into `x_rdata`. For a store, set `ls_rdata` to 0.
  - Go to RESP.
- RESP:
  - `x_rvalid=1`; memory idle (`mem_enable=0`, `mem_wr=0`).
  - Go to IDLE.
- `x_rdata` holds its value until the next response on that port.
- Requester must drop `req` in the cycle after seeing `gnt`. A `req` still high in IDLE is a new request.
- Simultaneous `if_req` and `ls_req`: one is granted. The loser stays pending and is served next in IDLE if still asserted.
- Reset values: state IDLE, all gnt/rvalid/mem_* outputs 0, rdata 0, latches 0, starvation counter 0, `busy=0`.
- `rst` during SERVE_LS with a store: `mem_enable` and `mem_wr` are gated by `!rst`, so no write occurs. The transaction is dropped with no rvalid.

## Timing
- Request seen in IDLE at cycle T → gnt and memory access at T+1 → rvalid and rdata at T+2.
- The arbiter is back in IDLE at T+3; the next grant is no earlier than T+4.
- Throughput: one access per 3 cycles.
- All outputs except `mem_*` are registered. `mem_*` are decoded from state plus latches; no combinational path from `*_req` to any output.
- Store commits at the rising edge ending T+1.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each LS grant made while `if_req` is high. It saturates at `STARVE_LIMIT`.
  - At `STARVE_LIMIT`, the next IDLE decision with `if_req` high grants IF.
  - The counter clears on any IF grant, or on an LS grant with `if_req` low.
- Undefined: strict LS priority; no counter logic; `STARVE_LIMIT` unused.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, SERVE_IF, SERVE_LS, RESP)
  - port ID constants (PORT_IF=0, PORT_LS=1)
  - default widths
- One sub-module, `arb_starve_cnt`: saturating counter with inc/clr/limit-hit. It is instantiated only under the macro.

## Test plan
- Reset: hold `rst` 2 cycles mid-SERVE_LS store to 0x40 → all outputs 0, memory at 0x40 unchanged, no `ls_rvalid`.
- Single fetch: `if_req`, `if_addr=0x0`, mem[0]=0x00500093 → `if_gnt` at T+1, `if_rvalid=1` and `if_rdata=0x00500093` at T+2.
- Store then load: store 0xDEADBEEF to 0x100, then load 0x100 → `ls_rdata=0` on the store response and 0xDEADBEEF on the load response.
- Collision: `if_req` and `ls_req` in the same IDLE cycle → LS granted first; IF granted at T+4.
- Starvation (macro on, `STARVE_LIMIT=4`): `ls_req` re-asserted continuously, `if_req` held → IF granted after exactly 4 LS grants. With the macro off, IF is never granted.
- Back-to-back hold: requester keeps `req` high after gnt → a second identical access is issued (verifies sampling only in IDLE).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_LS = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating counter of load/store grants made while fetch waits.
// Only instantiated by mem_arbiter when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !hit_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory2c between instruction fetch and load/store; LS wins ties.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT LS wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  arb_state_e        state_q;
  port_id_e          port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              if_gnt_q, ls_gnt_q, if_rvalid_q, ls_rvalid_q, busy_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  logic idle, serving, pick_if, pick_ls, starve_hit;

  assign idle    = (state_q == IDLE);
  assign serving = (state_q == SERVE_IF) || (state_q == SERVE_LS);
  assign pick_if = idle && if_req && (!ls_req || starve_hit);
  assign pick_ls = idle && ls_req && !pick_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pick_ls && if_req),
    .clr_i (pick_if || (pick_ls && !if_req)),
    .hit_o (starve_hit)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign starve_hit          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      port_q      <= PORT_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_ls) begin
            state_q  <= SERVE_LS;
            port_q   <= PORT_LS;
            addr_q   <= ls_addr;
            wdata_q  <= ls_wdata;
            wr_q     <= ls_wr;
            ls_gnt_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (pick_if) begin
            state_q  <= SERVE_IF;
            port_q   <= PORT_IF;
            addr_q   <= if_addr;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            if_gnt_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        SERVE_IF: begin
          if_rdata_q  <= mem_data_out;
          if_rvalid_q <= 1'b1;
          state_q     <= RESP;
        end
        SERVE_LS: begin
          ls_rdata_q  <= wr_q ? '0 : mem_data_out;
          ls_rvalid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Memory strobes are gated by rst so a reset landing on a store cannot commit it.
  assign mem_enable  = serving && !rst;
  assign mem_wr      = serving && (port_q == PORT_LS) && wr_q && !rst;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = busy_q;

endmodule
